sysref_gen: RTL and testbench
=============================

Name: sysref_gen

Overview:
- Sysref transmitter: generates a programmable periodic SYSREF pulse train in the sysClk domain.
- Drives the RFDC / clock-chip SYSREF path, or feeds the tile-sync period checker as loopback stimulus.
- Controlled through the sysClk CSR write path (sysCsrStrobe / GPIO_OUT).
- Reports run state and pulse count in a status register.

Parameters:
COUNTER_WIDTH, 8, width of period and phase counters; period max 2^COUNTER_WIDTH-1
WIDTH_BITS, 8, width of the pulse-high-width field

Ports:
sysClk  input  1  sole clock
sysReset_n  input  1  asynchronous, active-low reset
sysCsrStrobe  input  1  one-cycle CSR write qualifier
GPIO_OUT  input  32  CSR write data
syncIn  input  1  start trigger, already synchronous to sysClk, level-sampled
sysStatusReg  output  32  status word
sysrefOut  output  1  registered SYSREF pulse train
sysrefMarker  output  1  one-cycle pulse on each sysrefOut rising edge

Behaviour:
- Reset (async assert, sync release): sysrefOut=0, sysrefMarker=0, state IDLE, pulse count 0, period=16, width=1, shadows equal actives.
- CSR decode when sysCsrStrobe=1, command GPIO_OUT[31:30]:
  - 00 LOAD: period shadow <= [COUNTER_WIDTH-1:0]; width shadow <= [16+:WIDTH_BITS].
  - 01 START_CONT.
  - 10 START_BURST: N = [7:0].
  - 11 STOP.
  - GPIO_OUT[29] = arm flag; applies to START commands only.
- Clamping, applied when shadows are copied to actives: P<2 becomes 2; W=0 becomes 1; W>=P becomes P-1.
- Shadow to active copy:
  - immediately in IDLE or ARMED;
  - otherwise at the period boundary (phase wraps P-1 -> 0).
  - No mid-period change.
- States:
  - IDLE: output low. START with arm=0 -> RUN, phase=0. START with arm=1 -> ARMED.
  - ARMED: waits for syncIn=1, then -> RUN, phase=0. STOP -> IDLE immediately.
  - RUN: phase increments each cycle, wraps at P-1. sysrefOut=1 while phase<W. STOP -> STOPPING. Burst mode: after the Nth period completes -> IDLE.
  - STOPPING: continues until the current period ends (phase reaches P-1), then -> IDLE. Never a runt or truncated pulse.
- Latency:
  - Strobe (arm=0) sampled at edge k: sysrefOut high from edge k+1 through edge k+W.
  - syncIn sampled high at edge k: same timing.
  - sysrefMarker is high in the same cycle as the first high cycle of each pulse.
- START_BURST with N=0: no pulse, stays/returns IDLE.
- START while RUN or STOPPING: ignored.
- START while ARMED: re-arms with the new mode.
- sysCsrStrobe and syncIn in the same cycle while ARMED: the command wins; syncIn is ignored that cycle.
- Pulse count: 16-bit, increments on each rising edge, wraps mod 2^16, cleared on every accepted START.
- sysStatusReg bits:
  - [31] running (RUN or STOPPING)
  - [30] armed
  - [29] stopPending
  - [28] burstMode
  - [27:16] zero
  - [15:0] pulse count
- Reset asserted mid-pulse: sysrefOut drops asynchronously to 0.

Decomposition:
- Shared package:
  - command encodings (CMD_LOAD, CMD_START_CONT, CMD_START_BURST, CMD_STOP);
  - state encodings;
  - reset default period and width constants;
  - status bit indices.
- One natural sub-module: sysref_phase_counter. It holds phase, wrap detect, shadow/active registers and clamp logic; the FSM stays in the top level.

Test Plan:
1. Reset, LOAD P=10 W=3, START_CONT arm=0 at edge k -> sysrefOut high on edges k+1..k+3, low through k+10, repeats every 10 cycles; marker once per period.
2. START_BURST N=4 with P=8 W=2 -> exactly 4 pulses; state IDLE 32 cycles after start; status[15:0]=4, [31]=0.
3. START_CONT arm=1, syncIn low for 50 cycles then high at edge j -> no output before j; first rising edge at j+1; status[30] clears at j.
4. STOP issued at phase 1 of a 10-cycle period with W=3 -> pulse completes, output stays low to phase 9, then IDLE; no further rising edge.
5. LOAD P=1 W=0, then start -> period 2, width 1. LOAD P=6 W=9 while running -> new timing starts exactly at the next boundary, W clamped to 5.
6. Strobe START_BURST N=0, and START coincident with syncIn in ARMED -> no pulse, and the command wins. Reset mid-pulse -> sysrefOut 0 and count 0 immediately.

Source files
------------

// File: rtl/sysref_gen_pkg.sv
// Shared encodings and constants for the SYSREF pulse-train generator.
package sysref_gen_pkg;

   typedef enum logic [1:0] {
      CMD_LOAD        = 2'b00,
      CMD_START_CONT  = 2'b01,
      CMD_START_BURST = 2'b10,
      CMD_STOP        = 2'b11
   } cmd_e;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_ARMED,
      ST_RUN,
      ST_STOPPING
   } state_e;

   localparam int unsigned RESET_PERIOD = 16;
   localparam int unsigned RESET_WIDTH  = 1;

   localparam int unsigned CMD_LSB   = 30;
   localparam int unsigned ARM_BIT   = 29;
   localparam int unsigned WIDTH_LSB = 16;

   localparam int unsigned STAT_RUNNING      = 31;
   localparam int unsigned STAT_ARMED        = 30;
   localparam int unsigned STAT_STOP_PENDING = 29;
   localparam int unsigned STAT_BURST        = 28;

endpackage

// File: rtl/sysref_phase_counter.sv
// Phase counter with shadow/active period and width registers and clamping.
module sysref_phase_counter
   import sysref_gen_pkg::*;
#(
   parameter int unsigned COUNTER_WIDTH = 8,
   parameter int unsigned WIDTH_BITS    = 8
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     load,
   input  logic [COUNTER_WIDTH-1:0] load_period,
   input  logic [WIDTH_BITS-1:0]    load_width,
   input  logic                     count_en,
   output logic                     wrap,
   output logic                     pulse_on
);

   localparam int unsigned CW = (COUNTER_WIDTH > WIDTH_BITS) ? COUNTER_WIDTH : WIDTH_BITS;

   logic [COUNTER_WIDTH-1:0] phase;
   logic [COUNTER_WIDTH-1:0] period_shadow;
   logic [COUNTER_WIDTH-1:0] period_active;
   logic [WIDTH_BITS-1:0]    width_shadow;
   logic [WIDTH_BITS-1:0]    width_active;
   logic [CW-1:0]            period_c;
   logic [CW-1:0]            width_c;

   // Clamp is applied to the shadow values as they are promoted to active.
   always_comb begin
      period_c = CW'(period_shadow);
      if (period_c < CW'(2)) period_c = CW'(2);
      width_c = CW'(width_shadow);
      if (width_c == '0) width_c = CW'(1);
      if (width_c >= period_c) width_c = period_c - CW'(1);
   end

   assign wrap     = count_en && (phase == period_active - COUNTER_WIDTH'(1));
   assign pulse_on = CW'(phase) < CW'(width_active);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         phase         <= '0;
         period_shadow <= COUNTER_WIDTH'(RESET_PERIOD);
         period_active <= COUNTER_WIDTH'(RESET_PERIOD);
         width_shadow  <= WIDTH_BITS'(RESET_WIDTH);
         width_active  <= WIDTH_BITS'(RESET_WIDTH);
      end else begin
         if (load) begin
            period_shadow <= load_period;
            width_shadow  <= load_width;
         end
         if (!count_en || wrap) begin
            period_active <= COUNTER_WIDTH'(period_c);
            width_active  <= WIDTH_BITS'(width_c);
         end
         phase <= (count_en && !wrap) ? phase + COUNTER_WIDTH'(1) : '0;
      end
   end

endmodule

// File: rtl/sysref_gen.sv
// SYSREF transmitter: CSR-controlled periodic or burst pulse train in the sysClk domain.
module sysref_gen
   import sysref_gen_pkg::*;
#(
   parameter int unsigned COUNTER_WIDTH = 8,
   parameter int unsigned WIDTH_BITS    = 8
) (
   input  logic        sysClk,
   input  logic        sysReset_n,
   input  logic        sysCsrStrobe,
   input  logic [31:0] GPIO_OUT,
   input  logic        syncIn,
   output logic [31:0] sysStatusReg,
   output logic        sysrefOut,
   output logic        sysrefMarker
);

   state_e      state;
   cmd_e        cmd;
   logic        arm;
   logic [7:0]  burst_n;
   logic [7:0]  burst_left;
   logic        burst_mode;
   logic [15:0] pulse_count;
   logic        is_start;
   logic        is_stop;
   logic        running;
   logic        wrap;
   logic        pulse_on;
   logic        out_next;
   logic        rise;
   logic        unused_csr;

   assign cmd        = cmd_e'(GPIO_OUT[CMD_LSB +: 2]);
   assign arm        = GPIO_OUT[ARM_BIT];
   assign burst_n    = GPIO_OUT[7:0];
   assign is_start   = sysCsrStrobe && (cmd == CMD_START_CONT || cmd == CMD_START_BURST);
   assign is_stop    = sysCsrStrobe && (cmd == CMD_STOP);
   assign running    = (state == ST_RUN) || (state == ST_STOPPING);
   assign out_next   = running && pulse_on;
   assign rise       = out_next && !sysrefOut;
   assign unused_csr = ^GPIO_OUT;

   sysref_phase_counter #(
      .COUNTER_WIDTH (COUNTER_WIDTH),
      .WIDTH_BITS    (WIDTH_BITS)
   ) u_phase (
      .clk         (sysClk),
      .rst_n       (sysReset_n),
      .load        (sysCsrStrobe && (cmd == CMD_LOAD)),
      .load_period (GPIO_OUT[COUNTER_WIDTH-1:0]),
      .load_width  (GPIO_OUT[WIDTH_LSB +: WIDTH_BITS]),
      .count_en    (running),
      .wrap        (wrap),
      .pulse_on    (pulse_on)
   );

   always_ff @(posedge sysClk or negedge sysReset_n) begin
      if (!sysReset_n) begin
         state        <= ST_IDLE;
         sysrefOut    <= 1'b0;
         sysrefMarker <= 1'b0;
         pulse_count  <= '0;
         burst_mode   <= 1'b0;
         burst_left   <= '0;
      end else begin
         sysrefOut    <= out_next;
         sysrefMarker <= rise;
         if (rise) pulse_count <= pulse_count + 16'd1;
         case (state)
            ST_IDLE, ST_ARMED: begin
               if (is_start) begin
                  pulse_count <= '0;
                  burst_mode  <= (cmd == CMD_START_BURST);
                  burst_left  <= burst_n;
                  if (cmd == CMD_START_BURST && burst_n == '0) state <= ST_IDLE;
                  else if (arm)                                state <= ST_ARMED;
                  else                                         state <= ST_RUN;
               end else if (state == ST_ARMED) begin
                  // Any CSR write in the same cycle takes priority over the trigger.
                  if (is_stop)                          state <= ST_IDLE;
                  else if (syncIn && !sysCsrStrobe)     state <= ST_RUN;
               end
            end
            ST_RUN: begin
               if (wrap && burst_mode) begin
                  burst_left <= burst_left - 8'd1;
                  if (burst_left == 8'd1) state <= ST_IDLE;
               end
               if (is_stop) state <= wrap ? ST_IDLE : ST_STOPPING;
            end
            ST_STOPPING: begin
               if (wrap) state <= ST_IDLE;
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

   always_comb begin
      sysStatusReg                    = '0;
      sysStatusReg[STAT_RUNNING]      = running;
      sysStatusReg[STAT_ARMED]        = (state == ST_ARMED);
      sysStatusReg[STAT_STOP_PENDING] = (state == ST_STOPPING);
      sysStatusReg[STAT_BURST]        = burst_mode;
      sysStatusReg[15:0]              = pulse_count;
   end

endmodule

// File: tb/tb_sysref_gen.sv
// Randomized self-checking bench for sysref_gen against a behavioural period/phase model.
module tb_sysref_gen;

   logic        sysClk;
   logic        sysReset_n;
   logic        sysCsrStrobe;
   logic [31:0] GPIO_OUT;
   logic        syncIn;
   logic [31:0] sysStatusReg;
   logic        sysrefOut;
   logic        sysrefMarker;

   int vectors;
   int miscompares;

   bit m_run, m_armed, m_stop, m_burst, m_out, m_mark;
   int m_left, m_pos, m_P, m_W, m_sP, m_sW, m_cnt;

   sysref_gen #(
      .COUNTER_WIDTH (8),
      .WIDTH_BITS    (8)
   ) dut (
      .sysClk       (sysClk),
      .sysReset_n   (sysReset_n),
      .sysCsrStrobe (sysCsrStrobe),
      .GPIO_OUT     (GPIO_OUT),
      .syncIn       (syncIn),
      .sysStatusReg (sysStatusReg),
      .sysrefOut    (sysrefOut),
      .sysrefMarker (sysrefMarker)
   );

   initial sysClk = 1'b0;
   always #5 sysClk = ~sysClk;

   function automatic logic [31:0] mk_load(input int p, input int w);
      logic [31:0] d;
      d = '0;
      d[7:0]   = 8'(p);
      d[23:16] = 8'(w);
      return d;
   endfunction

   function automatic logic [31:0] mk_start(input bit burst, input bit arm, input int n);
      logic [31:0] d;
      d = '0;
      d[31:30] = burst ? 2'b10 : 2'b01;
      d[29]    = arm;
      d[7:0]   = 8'(n);
      return d;
   endfunction

   function automatic logic [31:0] mk_stop();
      logic [31:0] d;
      d = '0;
      d[31:30] = 2'b11;
      return d;
   endfunction

   function automatic logic [31:0] exp_status();
      logic [15:0] c;
      c = m_cnt[15:0];
      return {m_run, m_armed, m_stop, m_burst, 12'd0, c};
   endfunction

   task automatic model_reset();
      m_run = 0; m_armed = 0; m_stop = 0; m_burst = 0; m_out = 0; m_mark = 0;
      m_left = 0; m_pos = 0; m_cnt = 0;
      m_P = 16; m_W = 1; m_sP = 16; m_sW = 1;
   endtask

   // One clock edge of the reference: position within the period decides the output.
   task automatic model_step(input bit s, input logic [31:0] d, input bit y);
      int cmd, n, cp, cw;
      bit arm, boundary, want, is_start, is_stop;
      cmd      = int'(d[31:30]);
      n        = int'(d[7:0]);
      arm      = d[29];
      is_start = s && (cmd == 1 || cmd == 2);
      is_stop  = s && (cmd == 3);
      boundary = m_run && (m_pos == m_P - 1);
      want     = m_run && (m_pos < m_W);
      m_mark   = want && !m_out;
      m_out    = want;
      if (m_mark) m_cnt = (m_cnt + 1) % 65536;
      if (!m_run || boundary) begin
         cp = (m_sP < 2) ? 2 : m_sP;
         cw = (m_sW == 0) ? 1 : m_sW;
         if (cw >= cp) cw = cp - 1;
         m_P = cp;
         m_W = cw;
      end
      if (m_run) begin
         m_pos = boundary ? 0 : m_pos + 1;
         if (boundary && m_burst) begin
            m_left--;
            if (m_left == 0) m_run = 0;
         end
         if (boundary && m_stop) m_run = 0;
         if (is_stop) begin
            if (boundary) m_run = 0;
            else m_stop = 1;
         end
         if (!m_run) m_stop = 0;
      end else if (is_start) begin
         m_cnt = 0; m_burst = (cmd == 2); m_left = n; m_armed = 0;
         if (!(cmd == 2 && n == 0)) begin
            if (arm) m_armed = 1;
            else begin m_run = 1; m_pos = 0; end
         end
      end else if (m_armed && is_stop) begin
         m_armed = 0;
      end else if (m_armed && !s && y) begin
         m_armed = 0; m_run = 1; m_pos = 0;
      end
      if (s && cmd == 0) begin
         m_sP = int'(d[7:0]);
         m_sW = int'(d[23:16]);
      end
   endtask

   task automatic tick(input bit s, input logic [31:0] d, input bit y);
      sysCsrStrobe = s;
      GPIO_OUT     = d;
      syncIn       = y;
      @(posedge sysClk);
      model_step(s, d, y);
      #1;
      sysCsrStrobe = 1'b0;
      GPIO_OUT     = '0;
      syncIn       = 1'b0;
   endtask

   task automatic drain();
      tick(1, mk_stop(), 0);
      for (int i = 0; i < 300 && (m_run || m_armed); i++) begin
         tick(0, '0, 0);
         vectors++;
         if ({sysrefOut, sysrefMarker, sysStatusReg} !== {m_out, m_mark, exp_status()}) begin
            miscompares++;
            $display("FAIL drain cyc=%0d got out=%b mk=%b st=%h exp out=%b mk=%b st=%h",
                     i, sysrefOut, sysrefMarker, sysStatusReg, m_out, m_mark, exp_status());
         end
      end
      vectors++;
      if (sysStatusReg[31:30] !== 2'b00) begin
         miscompares++;
         $display("FAIL drain_idle got st=%h exp st[31:30]=00", sysStatusReg);
      end
   endtask

   task automatic test_reset();
      model_reset();
      sysReset_n = 1'b0;
      repeat (3) @(posedge sysClk);
      @(negedge sysClk);
      sysReset_n = 1'b1;
      vectors++;
      if ({sysrefOut, sysrefMarker, sysStatusReg} !== 34'd0) begin
         miscompares++;
         $display("FAIL reset_state got out=%b mk=%b st=%h exp all zero", sysrefOut, sysrefMarker, sysStatusReg);
      end
      tick(1, mk_start(0, 0, 0), 0);
      for (int i = 1; i <= 34; i++) begin
         tick(0, '0, 0);
         vectors++;
         if ({sysrefOut, sysrefMarker, sysStatusReg} !== {m_out, m_mark, exp_status()} ||
             sysrefOut !== (((i - 1) % 16) == 0)) begin
            miscompares++;
            $display("FAIL reset_defaults cyc=%0d got out=%b mk=%b st=%h exp out=%b mk=%b st=%h",
                     i, sysrefOut, sysrefMarker, sysStatusReg, m_out, m_mark, exp_status());
         end
      end
      drain();
   endtask

   task automatic test_continuous();
      tick(1, mk_load(10, 3), 0);
      tick(0, '0, 0);
      tick(1, mk_start(0, 0, 0), 0);
      for (int i = 1; i <= 35; i++) begin
         tick(0, '0, 0);
         vectors++;
         if ({sysrefOut, sysrefMarker, sysStatusReg} !== {m_out, m_mark, exp_status()} ||
             sysrefOut !== (((i - 1) % 10) < 3) || sysrefMarker !== (((i - 1) % 10) == 0)) begin
            miscompares++;
            $display("FAIL continuous cyc=%0d got out=%b mk=%b st=%h exp out=%b mk=%b st=%h",
                     i, sysrefOut, sysrefMarker, sysStatusReg, m_out, m_mark, exp_status());
         end
      end
      drain();
   endtask

   task automatic test_burst();
      int p, w, n;
      tick(1, mk_load(8, 2), 0);
      tick(0, '0, 0);
      tick(1, mk_start(1, 0, 4), 0);
      for (int i = 1; i <= 40; i++) begin
         tick(0, '0, 0);
         vectors++;
         if ({sysrefOut, sysrefMarker, sysStatusReg} !== {m_out, m_mark, exp_status()} ||
             (i == 31 && sysStatusReg[31] !== 1'b1) ||
             (i >= 32 && (sysStatusReg[31] !== 1'b0 || sysStatusReg[15:0] !== 16'd4))) begin
            miscompares++;
            $display("FAIL burst4 cyc=%0d got out=%b st=%h exp out=%b st=%h",
                     i, sysrefOut, sysStatusReg, m_out, exp_status());
         end
      end
      for (int r = 0; r < 3; r++) begin
         p = $urandom_range(2, 12);
         w = $urandom_range(1, p - 1);
         n = $urandom_range(1, 4);
         tick(1, mk_load(p, w), 0);
         tick(0, '0, 0);
         tick(1, mk_start(1, 0, n), 0);
         for (int i = 1; i <= p * n + 3; i++) begin
            tick(0, '0, 0);
            vectors++;
            if ({sysrefOut, sysrefMarker, sysStatusReg} !== {m_out, m_mark, exp_status()}) begin
               miscompares++;
               $display("FAIL burst_rand p=%0d n=%0d cyc=%0d got out=%b st=%h exp out=%b st=%h",
                        p, n, i, sysrefOut, sysStatusReg, m_out, exp_status());
            end
         end
         vectors++;
         if (sysStatusReg[31] !== 1'b0 || sysStatusReg[15:0] !== 16'(n)) begin
            miscompares++;
            $display("FAIL burst_count got st=%h exp count=%0d idle", sysStatusReg, n);
         end
      end
   endtask

   task automatic test_armed();
      int p, w, dly;
      p = $urandom_range(3, 12);
      w = $urandom_range(1, p - 1);
      dly = 50 + $urandom_range(0, 10);
      tick(1, mk_load(p, w), 0);
      tick(0, '0, 0);
      tick(1, mk_start(0, 1, 0), 0);
      for (int i = 1; i <= dly; i++) begin
         tick(0, '0, 0);
         vectors++;
         if ({sysrefOut, sysrefMarker, sysStatusReg} !== {m_out, m_mark, exp_status()} ||
             sysrefOut !== 1'b0 || sysStatusReg[30] !== 1'b1) begin
            miscompares++;
            $display("FAIL armed_wait cyc=%0d got out=%b st=%h exp out=0 armed", i, sysrefOut, sysStatusReg);
         end
      end
      tick(0, '0, 1);
      vectors++;
      if (sysStatusReg[30] !== 1'b0 || sysStatusReg[31] !== 1'b1 || sysrefOut !== 1'b0) begin
         miscompares++;
         $display("FAIL armed_sync got out=%b st=%h exp out=0 running", sysrefOut, sysStatusReg);
      end
      tick(0, '0, 0);
      vectors++;
      if (sysrefOut !== 1'b1 || sysrefMarker !== 1'b1 || sysStatusReg !== exp_status()) begin
         miscompares++;
         $display("FAIL armed_first got out=%b mk=%b st=%h exp out=1 mk=1 st=%h",
                  sysrefOut, sysrefMarker, sysStatusReg, exp_status());
      end
      drain();
   endtask

   task automatic test_stop();
      int rises;
      rises = 0;
      tick(1, mk_load(10, 3), 0);
      tick(0, '0, 0);
      tick(1, mk_start(0, 0, 0), 0);
      tick(0, '0, 0);
      tick(1, mk_stop(), 0);
      vectors++;
      if (sysStatusReg[31:29] !== 3'b101) begin
         miscompares++;
         $display("FAIL stop_pending got st=%h exp st[31:29]=101", sysStatusReg);
      end
      for (int i = 1; i <= 20; i++) begin
         tick(0, '0, 0);
         if (sysrefMarker) rises++;
         vectors++;
         if ({sysrefOut, sysrefMarker, sysStatusReg} !== {m_out, m_mark, exp_status()} ||
             sysrefOut !== (i == 1) || (i >= 8 && sysStatusReg[31] !== 1'b0) ||
             (i < 8 && sysStatusReg[31] !== 1'b1)) begin
            miscompares++;
            $display("FAIL stop cyc=%0d got out=%b st=%h exp out=%b st=%h",
                     i, sysrefOut, sysStatusReg, m_out, exp_status());
         end
      end
      vectors++;
      if (rises !== 0) begin
         miscompares++;
         $display("FAIL stop_no_rise got %0d rising edges exp 0", rises);
      end
   endtask

   task automatic test_clamp();
      int run_len, max_run;
      run_len = 0; max_run = 0;
      tick(1, mk_load(1, 0), 0);
      tick(0, '0, 0);
      tick(1, mk_start(0, 0, 0), 0);
      for (int i = 1; i <= 12; i++) begin
         tick(0, '0, 0);
         vectors++;
         if ({sysrefOut, sysrefMarker, sysStatusReg} !== {m_out, m_mark, exp_status()} ||
             sysrefOut !== (((i - 1) % 2) == 0)) begin
            miscompares++;
            $display("FAIL clamp_min cyc=%0d got out=%b st=%h exp out=%b st=%h",
                     i, sysrefOut, sysStatusReg, m_out, exp_status());
         end
      end
      tick(1, mk_load(6, 9), 0);
      for (int i = 1; i <= 40; i++) begin
         tick(0, '0, 0);
         run_len = sysrefOut ? run_len + 1 : 0;
         if (run_len > max_run) max_run = run_len;
         vectors++;
         if ({sysrefOut, sysrefMarker, sysStatusReg} !== {m_out, m_mark, exp_status()}) begin
            miscompares++;
            $display("FAIL clamp_reload cyc=%0d got out=%b st=%h exp out=%b st=%h",
                     i, sysrefOut, sysStatusReg, m_out, exp_status());
         end
      end
      vectors++;
      if (max_run !== 5) begin
         miscompares++;
         $display("FAIL clamp_width got longest pulse %0d exp 5", max_run);
      end
      drain();
   endtask

   task automatic test_corner();
      tick(1, mk_start(1, 0, 0), 0);
      vectors++;
      if (sysStatusReg[31:29] !== 3'b000 || sysStatusReg[15:0] !== 16'd0 || sysStatusReg !== exp_status()) begin
         miscompares++;
         $display("FAIL burst_zero got st=%h exp st=%h", sysStatusReg, exp_status());
      end
      for (int i = 1; i <= 6; i++) begin
         tick(0, '0, 0);
         vectors++;
         if (sysrefOut !== 1'b0 || sysStatusReg !== exp_status()) begin
            miscompares++;
            $display("FAIL burst_zero_idle cyc=%0d got out=%b st=%h exp out=0 st=%h",
                     i, sysrefOut, sysStatusReg, exp_status());
         end
      end
      tick(1, mk_start(0, 1, 0), 0);
      tick(1, mk_start(1, 1, 2), 1);
      vectors++;
      if (sysStatusReg[31:28] !== 4'b0101 || sysStatusReg !== exp_status()) begin
         miscompares++;
         $display("FAIL rearm_vs_sync got st=%h exp st=%h", sysStatusReg, exp_status());
      end
      tick(1, mk_load(5, 2), 1);
      vectors++;
      if (sysStatusReg[31:30] !== 2'b01 || sysrefOut !== 1'b0) begin
         miscompares++;
         $display("FAIL load_vs_sync got out=%b st=%h exp out=0 armed", sysrefOut, sysStatusReg);
      end
      tick(1, mk_stop(), 1);
      vectors++;
      if (sysStatusReg[31:30] !== 2'b00 || sysStatusReg !== exp_status()) begin
         miscompares++;
         $display("FAIL stop_vs_sync got st=%h exp st=%h", sysStatusReg, exp_status());
      end
      for (int i = 1; i <= 4; i++) begin
         tick(0, '0, 1);
         vectors++;
         if (sysrefOut !== 1'b0 || sysStatusReg !== exp_status()) begin
            miscompares++;
            $display("FAIL idle_ignores_sync cyc=%0d got out=%b st=%h exp out=0 st=%h",
                     i, sysrefOut, sysStatusReg, exp_status());
         end
      end
   endtask

   task automatic test_random();
      for (int i = 0; i < 400; i++) begin
         bit          s, y;
         logic [31:0] d;
         y = ($urandom_range(0, 3) == 0);
         s = ($urandom_range(0, 7) == 0);
         d = '0;
         if (s) begin
            case ($urandom_range(0, 3))
               0:       d = mk_load($urandom_range(0, 12), $urandom_range(0, 14));
               1:       d = mk_start(0, 1'($urandom_range(0, 1)), 0);
               2:       d = mk_start(1, 1'($urandom_range(0, 1)), $urandom_range(0, 4));
               default: d = mk_stop();
            endcase
         end
         tick(s, d, y);
         vectors++;
         if ({sysrefOut, sysrefMarker, sysStatusReg} !== {m_out, m_mark, exp_status()}) begin
            miscompares++;
            $display("FAIL random cyc=%0d got out=%b mk=%b st=%h exp out=%b mk=%b st=%h",
                     i, sysrefOut, sysrefMarker, sysStatusReg, m_out, m_mark, exp_status());
         end
      end
      drain();
   endtask

   task automatic test_reset_mid_pulse();
      tick(1, mk_load(12, 6), 0);
      tick(0, '0, 0);
      tick(1, mk_start(0, 0, 0), 0);
      repeat (3) tick(0, '0, 0);
      vectors++;
      if (sysrefOut !== 1'b1 || sysStatusReg[15:0] !== 16'd1) begin
         miscompares++;
         $display("FAIL pre_reset_pulse got out=%b st=%h exp out=1 count=1", sysrefOut, sysStatusReg);
      end
      #2;
      sysReset_n = 1'b0;
      #1;
      vectors++;
      if ({sysrefOut, sysrefMarker, sysStatusReg} !== 34'd0) begin
         miscompares++;
         $display("FAIL async_reset got out=%b mk=%b st=%h exp all zero", sysrefOut, sysrefMarker, sysStatusReg);
      end
      model_reset();
      @(negedge sysClk);
      sysReset_n = 1'b1;
      tick(0, '0, 0);
      vectors++;
      if ({sysrefOut, sysrefMarker, sysStatusReg} !== {m_out, m_mark, exp_status()}) begin
         miscompares++;
         $display("FAIL post_reset got out=%b st=%h exp out=%b st=%h", sysrefOut, sysStatusReg, m_out, exp_status());
      end
   endtask

   initial begin
      vectors      = 0;
      miscompares  = 0;
      sysReset_n   = 1'b0;
      sysCsrStrobe = 1'b0;
      GPIO_OUT     = '0;
      syncIn       = 1'b0;
      test_reset();
      test_continuous();
      test_burst();
      test_armed();
      test_stop();
      test_clamp();
      test_corner();
      test_random();
      test_reset_mid_pulse();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
